// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - operand stack with push/pop/tos, occupancy and sticky error flags
// Optional macro STACK_PEEK2_EN adds o_nos and i_swap.
module stack_unit #(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 16,
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic              i_tos,
   input  logic              i_mtos,
   input  logic [DATA_W-1:0] i_mem_din,
   input  logic [DATA_W-1:0] i_alu_din,
`ifdef STACK_PEEK2_EN
   input  logic              i_swap,
   output logic [DATA_W-1:0] o_nos,
`endif
   output logic [DATA_W-1:0] o_dout,
   output logic [CNT_W-1:0]  o_count,
   output logic              o_empty,
   output logic              o_full,
   output logic              o_ovf_err,
   output logic              o_unf_err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [CNT_W-1:0]  r_count;
   logic [DATA_W-1:0] r_dout;
   logic              r_ovf;
   logic              r_unf;

   logic [DATA_W-1:0] w_push_data;
   logic [DATA_W-1:0] w_top;
   logic [PTR_W-1:0]  w_top_idx;
   logic [PTR_W-1:0]  w_wr_idx;
   logic              w_empty;
   logic              w_full;
   logic              w_we;
   logic [PTR_W-1:0]  w_widx;
   logic              w_swap_do;
   logic [CNT_W-1:0]  w_next_count;
   logic [DATA_W-1:0] w_next_dout;
   logic              w_next_ovf;
   logic              w_next_unf;

   // Truncating the pointer makes count==DEPTH wrap to index DEPTH-1 for the top entry.
   assign w_wr_idx    = r_count[PTR_W-1:0];
   assign w_top_idx   = w_wr_idx - PTR_W'(1);
   assign w_top       = r_mem[w_top_idx];
   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == CNT_W'(DEPTH));
   assign w_push_data = i_mtos ? i_mem_din : i_alu_din;

`ifdef STACK_PEEK2_EN
   logic [PTR_W-1:0] w_nos_idx;
   logic             w_two;
   assign w_nos_idx = w_wr_idx - PTR_W'(2);
   assign w_two     = (r_count >= CNT_W'(2));
   assign o_nos     = w_two ? r_mem[w_nos_idx] : '0;
`endif

   always_comb begin
      w_next_count = r_count;
      w_next_dout  = r_dout;
      w_next_ovf   = r_ovf;
      w_next_unf   = r_unf;
      w_we         = 1'b0;
      w_widx       = w_wr_idx;
      w_swap_do    = 1'b0;
      if (i_push && i_pop) begin
         w_we = 1'b1;
         if (!w_empty) begin
            w_next_dout = w_top;
            w_widx      = w_top_idx;
         end else begin
            w_widx       = '0;
            w_next_count = CNT_W'(1);
            w_next_unf   = 1'b1;
         end
      end else if (i_push) begin
         if (i_tos)
            w_next_dout = w_empty ? '0 : w_top;
         if (!w_full) begin
            w_we         = 1'b1;
            w_next_count = r_count + CNT_W'(1);
         end else begin
            w_next_ovf = 1'b1;
         end
      end else if (i_pop) begin
         if (!w_empty) begin
            w_next_dout  = w_top;
            w_next_count = r_count - CNT_W'(1);
         end else begin
            w_next_unf = 1'b1;
         end
      end else if (i_tos) begin
         w_next_dout = w_empty ? '0 : w_top;
`ifdef STACK_PEEK2_EN
      end else if (i_swap) begin
         if (w_two)
            w_swap_do = 1'b1;
         else
            w_next_unf = 1'b1;
`endif
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (w_we)
         r_mem[w_widx] <= w_push_data;
`ifdef STACK_PEEK2_EN
      if (w_swap_do) begin
         r_mem[w_top_idx] <= r_mem[w_nos_idx];
         r_mem[w_nos_idx] <= r_mem[w_top_idx];
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         r_dout  <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else begin
         r_count <= w_next_count;
         r_dout  <= w_next_dout;
         r_ovf   <= w_next_ovf;
         r_unf   <= w_next_unf;
      end
   end

`ifndef STACK_PEEK2_EN
   logic w_unused;
   assign w_unused = w_swap_do;
`endif

   assign o_dout    = r_dout;
   assign o_count   = r_count;
   assign o_empty   = w_empty;
   assign o_full    = w_full;
   assign o_ovf_err = r_ovf;
   assign o_unf_err = r_unf;

endmodule

// File: tb/tb_stack_unit.sv
// tb/tb_stack_unit.sv - self-checking bench for stack_unit against a queue-based stack model
module tb_stack_unit;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 16;
   localparam int CNT_W  = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              i_push = 1'b0, i_pop = 1'b0, i_tos = 1'b0, i_mtos = 1'b0;
   logic [DATA_W-1:0] i_mem_din = '0, i_alu_din = '0;
   logic              i_swap = 1'b0;
   logic [DATA_W-1:0] o_nos;
   logic [DATA_W-1:0] o_dout;
   logic [CNT_W-1:0]  o_count;
   logic              o_empty, o_full, o_ovf_err, o_unf_err;

   stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_push    (i_push),
      .i_pop     (i_pop),
      .i_tos     (i_tos),
      .i_mtos    (i_mtos),
      .i_mem_din (i_mem_din),
      .i_alu_din (i_alu_din),
`ifdef STACK_PEEK2_EN
      .i_swap    (i_swap),
      .o_nos     (o_nos),
`endif
      .o_dout    (o_dout),
      .o_count   (o_count),
      .o_empty   (o_empty),
      .o_full    (o_full),
      .o_ovf_err (o_ovf_err),
      .o_unf_err (o_unf_err)
   );

`ifndef STACK_PEEK2_EN
   assign o_nos = '0;
`endif

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   logic [DATA_W-1:0] q[$];
   logic [DATA_W-1:0] m_dout = '0;
   bit                m_ovf = 1'b0, m_unf = 1'b0;

   task automatic check(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("dout",  int'(o_dout),    int'(m_dout));
         check("count", int'(o_count),   q.size());
         check("empty", int'(o_empty),   int'(q.size() == 0));
         check("full",  int'(o_full),    int'(q.size() == DEPTH));
         check("ovf",   int'(o_ovf_err), int'(m_ovf));
         check("unf",   int'(o_unf_err), int'(m_unf));
`ifdef STACK_PEEK2_EN
         check("nos",   int'(o_nos),     (q.size() >= 2) ? int'(q[q.size()-2]) : 0);
`endif
      end
   end

   task automatic model_clear();
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
   endtask

   task automatic model_step(input bit pu, input bit po, input bit t, input bit sw, input logic [DATA_W-1:0] d);
      logic [DATA_W-1:0] tmp;
      bit e, f;
      e = (q.size() == 0);
      f = (q.size() == DEPTH);
      if (pu && po) begin
         if (!e) begin
            m_dout = q[$];
            q[$]   = d;
         end else begin
            q.push_back(d);
            m_unf = 1'b1;
         end
      end else if (pu) begin
         if (t) m_dout = e ? '0 : q[$];
         if (!f) q.push_back(d);
         else    m_ovf = 1'b1;
      end else if (po) begin
         if (!e) m_dout = q.pop_back();
         else    m_unf = 1'b1;
      end else if (t) begin
         m_dout = e ? '0 : q[$];
      end else if (sw) begin
         if (q.size() >= 2) begin
            tmp = q[$];
            q[q.size()-1] = q[q.size()-2];
            q[q.size()-2] = tmp;
         end else begin
            m_unf = 1'b1;
         end
      end
   endtask

   task automatic cmd(input bit pu, input bit po, input bit t, input bit mt,
                      input logic [DATA_W-1:0] md, input logic [DATA_W-1:0] ad, input bit sw = 1'b0);
      @(negedge clk);
      i_push = pu; i_pop = po; i_tos = t; i_mtos = mt;
      i_mem_din = md; i_alu_din = ad; i_swap = sw;
      @(posedge clk);
      #1;
      model_step(pu, po, t, sw, mt ? md : ad);
      i_push = 1'b0; i_pop = 1'b0; i_tos = 1'b0; i_swap = 1'b0;
   endtask

   task automatic push_alu(input logic [DATA_W-1:0] v);
      cmd(1, 0, 0, 0, 8'h5A, v);
   endtask

   task automatic async_reset();
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      model_clear();
      check("rst_count", int'(o_count),   0);
      check("rst_dout",  int'(o_dout),    0);
      check("rst_ovf",   int'(o_ovf_err), 0);
      check("rst_unf",   int'(o_unf_err), 0);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      #12;
      check("init_count", int'(o_count), 0);
      check("init_dout",  int'(o_dout),  0);
      check("init_empty", int'(o_empty), 1);
      rst = 1'b0;
      chk_en = 1'b1;

      cmd(1, 0, 0, 1, 8'h11, 8'h99);
      cmd(1, 0, 0, 0, 8'h99, 8'h22);
      cmd(0, 0, 1, 0, 8'h00, 8'h00);
      check("tp1_count", int'(o_count), 2);
      check("tp1_dout",  int'(o_dout),  8'h22);
      check("tp1_err",   int'({o_ovf_err, o_unf_err}), 0);

      cmd(0, 1, 0, 0, 8'h00, 8'h00);
      check("tp2_pop1", int'(o_dout), 8'h22);
      cmd(0, 1, 0, 0, 8'h00, 8'h00);
      check("tp2_pop2", int'(o_dout), 8'h11);
      check("tp2_empty", int'(o_empty), 1);
      cmd(0, 1, 0, 0, 8'h00, 8'h00);
      check("tp2_unf_dout", int'(o_dout), 8'h11);
      check("tp2_unf", int'(o_unf_err), 1);
      cmd(0, 0, 0, 0, 8'h00, 8'h00);
      check("tp2_unf_sticky", int'(o_unf_err), 1);

      async_reset();
      for (int i = 0; i < DEPTH; i++) push_alu(8'(i));
      check("tp3_full", int'(o_full), 1);
      check("tp3_ovf0", int'(o_ovf_err), 0);
      cmd(1, 0, 1, 1, 8'hAA, 8'h00);
      check("tp3_count", int'(o_count), 16);
      check("tp3_ovf", int'(o_ovf_err), 1);
      check("tp3_tos_full", int'(o_dout), 15);
      cmd(0, 1, 0, 0, 8'h00, 8'h00);
      check("tp3_pop", int'(o_dout), 15);
      check("tp3_count15", int'(o_count), 15);

      async_reset();
      push_alu(8'h05);
      push_alu(8'h07);
      cmd(1, 1, 0, 0, 8'h00, 8'h09);
      check("tp4_rep_dout", int'(o_dout), 8'h07);
      check("tp4_rep_count", int'(o_count), 2);
      cmd(0, 1, 0, 0, 8'h00, 8'h00);
      check("tp4_pop", int'(o_dout), 8'h09);
      cmd(1, 0, 1, 1, 8'h33, 8'h00);
      check("push_tos_pre", int'(o_dout), 8'h05);
      cmd(0, 1, 0, 0, 8'h00, 8'h00);
      cmd(0, 1, 0, 0, 8'h00, 8'h00);
      cmd(1, 1, 0, 1, 8'h44, 8'h00);
      check("pp_empty_count", int'(o_count), 1);
      check("pp_empty_unf", int'(o_unf_err), 1);
      check("pp_empty_dout", int'(o_dout), 8'h05);

      async_reset();
      cmd(1, 0, 1, 0, 8'h00, 8'h61);
      check("push_tos_empty", int'(o_dout), 0);
      push_alu(8'h62);
      push_alu(8'h63);
      cmd(0, 0, 1, 0, 8'h00, 8'h00);
      check("tp5_pre_dout", int'(o_dout), 8'h63);
      check("tp5_pre_count", int'(o_count), 3);
      async_reset();
      cmd(0, 0, 1, 0, 8'h00, 8'h00);
      check("tp5_tos_after_rst", int'(o_dout), 0);

`ifdef STACK_PEEK2_EN
      cmd(0, 0, 0, 0, 8'h00, 8'h00, 1'b1);
      check("swap_empty_unf", int'(o_unf_err), 1);
      async_reset();
      push_alu(8'h01);
      push_alu(8'h02);
      check("peek_nos_pre", int'(o_nos), 8'h01);
      cmd(0, 0, 0, 0, 8'h00, 8'h00, 1'b1);
      check("swap_nos", int'(o_nos), 8'h02);
      check("swap_unf0", int'(o_unf_err), 0);
      cmd(0, 1, 0, 0, 8'h00, 8'h00);
      check("swap_pop", int'(o_dout), 8'h01);
      check("swap_nos_one", int'(o_nos), 0);
`endif

      @(negedge clk);
      #1;
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
